// File: rtl/ram_bus_if.sv
// Request/response handshake and RAM strobe bundle for ram_bus_master.
// The bidirectional RAM data bus stays a plain module port.
interface ram_bus_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic                  mem_cs;
  logic                  mem_we;
  logic                  mem_oe;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata,
    output mem_address, mem_cs, mem_we, mem_oe
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata,
    input  mem_address, mem_cs, mem_we, mem_oe
  );
endinterface

// File: rtl/ram_bus_master.sv
// Initiator for the asynchronous tri-state RAM bus: sequences cs/we/oe with setup, hold and turnaround.
// Optional macro RAM_BUS_MASTER_STATS_EN adds saturating rd_count/wr_count outputs.
module ram_bus_master #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned RD_WAIT    = 1,
  parameter int unsigned WR_PULSE   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  ram_bus_if.master             bus,
  inout  wire  [DATA_WIDTH-1:0] mem_data
`ifdef RAM_BUS_MASTER_STATS_EN
  ,
  output logic [15:0]           rd_count,
  output logic [15:0]           wr_count
`endif
);

  localparam int unsigned MAX_WAIT = (RD_WAIT > WR_PULSE) ? RD_WAIT : WR_PULSE;
  localparam int unsigned CW       = $clog2(MAX_WAIT) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_SETUP,
    S_WR_STROBE,
    S_WR_HOLD,
    S_RD_WAIT,
    S_TURN
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  ready_q, ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  cs_q, cs_d;
  logic                  we_q, we_d;
  logic                  oe_q, oe_d;
  logic                  drive_q, drive_d;

  // State and registered bus outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      cs_q        <= 1'b0;
      we_q        <= 1'b0;
      oe_q        <= 1'b0;
      drive_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      cs_q        <= cs_d;
      we_q        <= we_d;
      oe_q        <= oe_d;
      drive_q     <= drive_d;
    end
  end

  // Next state; outputs are decoded from the next state so they register in step with it
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          if (bus.req_we) begin
            state_d = S_WR_SETUP;
          end else begin
            state_d = S_RD_WAIT;
            cnt_d   = CW'(RD_WAIT - 1);
          end
        end
      end
      S_WR_SETUP: begin
        state_d = S_WR_STROBE;
        cnt_d   = CW'(WR_PULSE - 1);
      end
      S_WR_STROBE: begin
        if (cnt_q == '0) state_d = S_WR_HOLD;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_WR_HOLD: state_d = S_IDLE;
      S_RD_WAIT: begin
        if (cnt_q == '0) begin
          rdata_d = mem_data;
          state_d = S_TURN;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_TURN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    ready_d     = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_TURN);
    drive_d     = (state_d == S_WR_SETUP) || (state_d == S_WR_STROBE) || (state_d == S_WR_HOLD);
    cs_d        = drive_d || (state_d == S_RD_WAIT);
    we_d        = (state_d == S_WR_STROBE);
    oe_d        = (state_d == S_RD_WAIT);
  end

  assign bus.req_ready   = ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rdata_q;
  assign bus.mem_address = addr_q;
  assign bus.mem_cs      = cs_q;
  assign bus.mem_we      = we_q;
  assign bus.mem_oe      = oe_q;
  // Data is only driven in write states, where oe is guaranteed low
  assign mem_data        = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};

`ifdef RAM_BUS_MASTER_STATS_EN
  logic [15:0] rd_count_q, wr_count_q;
  logic        rd_inc, wr_inc;

  assign rd_inc = (state_q == S_RD_WAIT)   && (state_d == S_TURN);
  assign wr_inc = (state_q == S_WR_STROBE) && (state_d == S_WR_HOLD);

  // Saturating transaction counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      if (rd_inc && (rd_count_q != 16'hFFFF)) rd_count_q <= rd_count_q + 16'd1;
      if (wr_inc && (wr_count_q != 16'hFFFF)) wr_count_q <= wr_count_q + 16'd1;
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_ram_bus_master.sv
// Self-checking bench for ram_bus_master with a behavioural RAM and expected-memory model.
module tb_ram_bus_master;
  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 32;
  localparam int unsigned RDW = 2;
  localparam int unsigned WRP = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ram_bus_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  tri1 [DW-1:0] mem_data;
`ifdef RAM_BUS_MASTER_STATS_EN
  logic [15:0] rd_count, wr_count;
`endif

  ram_bus_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_WAIT(RDW), .WR_PULSE(WRP)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .mem_data (mem_data)
`ifdef RAM_BUS_MASTER_STATS_EN
    ,
    .rd_count (rd_count),
    .wr_count (wr_count)
`endif
  );

  // Behavioural RAM: writes on we && !oe, drives on cs && oe && !we
  logic [DW-1:0] ram [256];
  logic          pl_en = 1'b0;
  logic [7:0]    pl_a  = '0;
  logic [DW-1:0] pl_d  = '0;
  wire           ram_drive = bus.mem_cs && bus.mem_oe && !bus.mem_we;
  assign mem_data = ram_drive ? ram[bus.mem_address[7:0]] : {DW{1'bz}};

  always @(posedge clk) begin
    if (pl_en) ram[pl_a] <= pl_d;
    else if (bus.mem_we && !bus.mem_oe) ram[bus.mem_address[7:0]] <= mem_data;
  end

  int rule_viol = 0;
  int rsp_seen  = 0;
  always @(negedge clk) begin
    if (bus.mem_we && bus.mem_oe) rule_viol <= rule_viol + 1;
    if (bus.rsp_valid) rsp_seen <= rsp_seen + 1;
  end

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] model [256];
  logic [DW-1:0] last_rd = '0;
  int            exp_rd_cnt = 0;
  int            exp_wr_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one request at the current negedge; returns at the negedge where req_ready is back
  task automatic run_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    int n = 0;
    int ready_c = 0, we_cnt = 0, first_we = 0, rsp_c = 0, rsp_cnt = 0;
    logic addr_bad = 0, oe_bad = 0, data_bad = 0, cs_bad = 0, turn_bad = 0, rd_x = 0;
    logic [DW-1:0] exp_rd, got_rd;
    got_rd = '0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", 64'(bus.req_ready), 64'd1);
    exp_rd = model[addr[7:0]];
    if (we) model[addr[7:0]] = wdata;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'($urandom_range(0, 1));
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (bus.mem_cs && bus.mem_address !== addr) addr_bad = 1;
      if (we) begin
        if (bus.mem_we) begin
          we_cnt++;
          if (first_we == 0) first_we = c;
        end
        if (bus.mem_oe) oe_bad = 1;
        if (c <= int'(2 + WRP) && (mem_data !== wdata || !bus.mem_cs)) data_bad = 1;
      end else begin
        if (bus.rsp_valid) begin
          rsp_cnt++;
          rsp_c  = c;
          got_rd = bus.rsp_rdata;
          if (bus.mem_cs || bus.mem_oe || mem_data !== {DW{1'b1}}) turn_bad = 1;
        end
        if (c <= int'(RDW)) begin
          if ($isunknown(mem_data)) rd_x = 1;
          if (!(bus.mem_cs && bus.mem_oe) || bus.mem_we) cs_bad = 1;
        end
      end
      if (bus.req_ready) begin
        ready_c = c;
        break;
      end
    end
    check("addr_passthrough", 64'(addr_bad), 64'd0);
    if (we) begin
      check("wr_ready_latency", 64'(ready_c), 64'(3 + WRP));
      check("wr_we_cycles", 64'(we_cnt), 64'(WRP));
      check("wr_we_first", 64'(first_we), 64'd2);
      check("wr_oe_low", 64'(oe_bad), 64'd0);
      check("wr_data_driven", 64'(data_bad), 64'd0);
      check("rdata_hold", 64'(bus.rsp_rdata), 64'(last_rd));
      exp_wr_cnt++;
    end else begin
      check("rd_ready_latency", 64'(ready_c), 64'(RDW + 2));
      check("rd_rsp_cycle", 64'(rsp_c), 64'(RDW + 1));
      check("rd_rsp_pulses", 64'(rsp_cnt), 64'd1);
      check("rd_data", 64'(got_rd), 64'(exp_rd));
      check("rd_strobes", 64'(cs_bad), 64'd0);
      check("rd_no_x", 64'(rd_x), 64'd0);
      check("rd_turn", 64'(turn_bad), 64'd0);
      last_rd = exp_rd;
      exp_rd_cnt++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 64'(bus.req_ready), 64'd1);
    check({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
    check({tag, "_rdata"}, 64'(bus.rsp_rdata), 64'd0);
    check({tag, "_cs"}, 64'(bus.mem_cs), 64'd0);
    check({tag, "_we"}, 64'(bus.mem_we), 64'd0);
    check({tag, "_oe"}, 64'(bus.mem_oe), 64'd0);
    check({tag, "_addr"}, 64'(bus.mem_address), 64'd0);
    check({tag, "_bus_released"}, 64'(mem_data), 64'({DW{1'b1}}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    logic [DW-1:0] v;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    // Reset rises mid-cycle; outputs must take reset values without a clock edge
    #3 rst = 1'b1;
    #1 check_reset_outputs("reset");

    for (int i = 0; i < 256; i++) begin
      v = (i == 32'h20) ? 32'h1234_5678 : $urandom;
      model[i] = v;
      pl_a  = 8'(i);
      pl_d  = v;
      pl_en = 1'b1;
      @(posedge clk);
      #1;
    end
    pl_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("idle");

    run_txn(1'b1, 32'h10, 32'hDEAD_BEEF);
    check("ram_0x10", 64'(ram[8'h10]), 64'h0000_0000_DEAD_BEEF);
    run_txn(1'b0, 32'h20, '0);
    check("rd_0x20_value", 64'(bus.rsp_rdata), 64'h0000_0000_1234_5678);
    // Write then read the same word back-to-back
    run_txn(1'b1, 32'h5, 32'hA5A5_A5A5);
    run_txn(1'b0, 32'h5, '0);
    check("b2b_rdata", 64'(bus.rsp_rdata), 64'h0000_0000_A5A5_A5A5);
    run_txn(1'b0, 32'h10, '0);

    for (int k = 0; k < 24; k++) begin
      base = int'($urandom_range(0, 255));
      run_txn(1'($urandom_range(0, 1)), {$urandom, 8'(base)} >> 8 << 8 | AW'(base), $urandom);
    end

    // Reset during the write strobe: strobe drops at once and no response follows
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h40; bus.req_wdata = 32'h1111_2222;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midwr_in_strobe", 64'(bus.mem_we), 64'd1);
    base = rsp_seen;
    rst = 1'b1;
    #1;
    check("midwr_we_drop", 64'(bus.mem_we), 64'd0);
    check("midwr_cs_drop", 64'(bus.mem_cs), 64'd0);
    check("midwr_bus_released", 64'(mem_data), 64'({DW{1'b1}}));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last_rd = '0;
    exp_rd_cnt = 0;
    exp_wr_cnt = 0;
    repeat (3) @(negedge clk);
    check("midwr_no_rsp", 64'(rsp_seen - base), 64'd0);
    check("midwr_idle", 64'(bus.req_ready), 64'd1);
    run_txn(1'b0, 32'h40, '0);

    // Reset during the read wait
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 32'h20;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    check("midrd_in_wait", 64'(bus.mem_oe), 64'd1);
    base = rsp_seen;
    rst = 1'b1;
    #1;
    check("midrd_oe_drop", 64'(bus.mem_oe), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last_rd = '0;
    exp_rd_cnt = 0;
    exp_wr_cnt = 0;
    repeat (4) @(negedge clk);
    check("midrd_no_rsp", 64'(rsp_seen - base), 64'd0);
    check("midrd_rdata_cleared", 64'(bus.rsp_rdata), 64'd0);
    check("midrd_idle", 64'(bus.req_ready), 64'd1);

`ifdef RAM_BUS_MASTER_STATS_EN
    for (int k = 0; k < 3; k++) run_txn(1'b1, AW'(8'h60 + 8'(k)), $urandom);
    for (int k = 0; k < 2; k++) run_txn(1'b0, AW'(8'h60 + 8'(k)), '0);
    check("stats_wr", 64'(wr_count), 64'(exp_wr_cnt));
    check("stats_rd", 64'(rd_count), 64'(exp_rd_cnt));
    check("stats_wr_3", 64'(wr_count), 64'd3);
    check("stats_rd_2", 64'(rd_count), 64'd2);
    force dut.rd_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.rd_count_q;
    run_txn(1'b0, 32'h60, '0);
    check("stats_rd_saturate", 64'(rd_count), 64'hFFFF);
`endif

    check("we_oe_exclusive", 64'(rule_viol), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_bus_master.md
Name: ram_bus_master

Overview:
- Initiator for the single-port asynchronous tri-state RAM bus: address, bidirectional data, cs, we, oe.
- Accepts read/write requests on a valid/ready handshake, sequences the RAM strobes with safe setup, hold and turnaround timing, and returns read data as a one-cycle response pulse.
- Sits between the core's load/store path and the simulation RAM model.

Parameters:
- DATA_WIDTH, 32, data bus width
- ADDR_WIDTH, 32, address width
- RD_WAIT, 1, cycles cs/oe are held before read data is sampled (min 1)
- WR_PULSE, 1, cycles we is held high (min 1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  request address
- req_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  one-cycle pulse: read data valid
- rsp_rdata  out  DATA_WIDTH  captured read data
- mem_address  out  ADDR_WIDTH  RAM address
- mem_data  inout  DATA_WIDTH  RAM data bus
- mem_cs  out  1  chip select
- mem_we  out  1  write enable
- mem_oe  out  1  output enable

Behaviour:
- RAM contract: the RAM writes whenever we=1 and oe=0, regardless of cs. It drives the data bus when cs=1, oe=1 and we=0.
- Master rule 1: mem_we may be 1 only while mem_oe=0.
- Master rule 2: the master drives mem_data only in WR_* states, where oe=0. Otherwise mem_data is high-Z.
- Reset (async): state=IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; mem_cs=0; mem_we=0; mem_oe=0; mem_address=0; mem_data high-Z.
- Reset mid-transaction aborts immediately, with no response and no partial write strobe after rst rises.
- All mem_* outputs and rsp_* are registered.
- Handshake: a request is accepted on a clk edge with req_valid && req_ready.
  - req_ready=1 only in IDLE.
  - req_addr, req_wdata and req_we are captured at acceptance; later changes are ignored.
  - No response backpressure: rsp_valid is a pulse.
- FSM states: IDLE, WR_SETUP, WR_STROBE, WR_HOLD, RD_WAIT, TURN.
- IDLE: cs=0, we=0, oe=0, bus released. Accept goes to WR_SETUP (write) or RD_WAIT (read).
- WR_SETUP (1 cycle): cs=1, oe=0, we=0; address and data driven.
- WR_STROBE (WR_PULSE cycles): we=1; address and data stable.
- WR_HOLD (1 cycle): we=0; address and data still driven. Next state IDLE.
- Write latency: accept at edge N; we high for cycles N+2..N+1+WR_PULSE; req_ready=1 again at N+3+WR_PULSE.
- RD_WAIT (RD_WAIT cycles): cs=1, oe=1, we=0, bus released. On the last cycle's closing edge: rsp_rdata <= mem_data, and the next state is TURN.
- TURN (1 cycle): rsp_valid=1; cs=0, oe=0; bus still released (turnaround, so no contention with a following write). Next state IDLE.
- Read latency: rsp_valid is high in cycle N+RD_WAIT+1; req_ready=1 at N+RD_WAIT+2.
- rsp_rdata holds its value until the next read capture.
- A wait counter of width clog2(max(RD_WAIT,WR_PULSE))+1 counts down and reloads on state entry.
- Back-to-back requests each pay the full sequence; there is no pipelining.
- Addresses are passed through unmodified, with no wrap or range check.

Optional Feature:
- Macro: RAM_BUS_MASTER_STATS_EN
- With the macro defined:
  - Adds outputs rd_count[15:0] and wr_count[15:0].
  - rd_count increments on each rsp_valid; wr_count increments on each WR_HOLD entry.
  - Both counters saturate at 16'hFFFF and are cleared by rst.
- Without the macro: the ports and logic are absent, and behaviour is otherwise identical.

Test Plan:
- Reset then idle: rst pulse mid-cycle -> outputs immediately at reset values; mem_data reads Z; req_ready=1.
- Write: req_we=1, addr=0x10, wdata=0xDEADBEEF, WR_PULSE=1 -> RAM word 0x10 = 0xDEADBEEF. we high exactly 1 cycle, oe=0 throughout, data driven from setup through hold. req_ready back 4 cycles after accept.
- Read: preload word 0x20=0x12345678, RD_WAIT=2 -> rsp_valid pulse 3 cycles after accept with rsp_rdata=0x12345678. No driver conflict (no X on mem_data).
- Write then read same address back-to-back (req_valid held): write 0xA5A5A5A5 to 0x5 then read 0x5 -> rsp_rdata=0xA5A5A5A5; TURN cycle present; we never 1 while oe=1.
- Reset mid-write: assert rst during WR_STROBE -> we drops immediately, no rsp_valid, FSM in IDLE after release. Reset mid-read -> no rsp_valid.
- Stats (macro on): 3 writes + 2 reads -> wr_count=3, rd_count=2. Force count to 0xFFFF, one more read -> stays 0xFFFF.
